// File: rtl/pe_sum_drain.sv
// rtl/pe_sum_drain.sv - snapshot of per-PE partial sums drained over a valid/ready stream
module pe_sum_drain #(
  parameter int NUM_PE = 4,
  parameter int SUM_W  = 20,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture,
  input  logic [NUM_PE*SUM_W-1:0] pe_sums,
  input  logic                    clear_overrun,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PE - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic [SUM_W-1:0] shadow_q [NUM_PE];

  logic drain, xfer, final_xfer, load, lost;

  always_comb begin
    drain      = (state_q == DRAIN);
    xfer       = drain && out_ready;
    final_xfer = xfer && (idx_q == LAST);
    // A capture landing on the final transfer starts the next tile with no bubble.
    load       = capture && (!drain || final_xfer);
    lost       = capture && drain && !final_xfer;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = final_xfer;
    overrun_d = overrun_q;
    case (state_q)
      IDLE:  if (capture) state_d = DRAIN;
      DRAIN: if (final_xfer) state_d = capture ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      idx_d = '0;
    end else if (xfer && !final_xfer) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (lost) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) shadow_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_PE; i++) shadow_q[i] <= pe_sums[i*SUM_W +: SUM_W];
    end
  end

  // Outputs come only from registered state and the shadow, never from pe_sums.
  always_comb begin
    out_valid = drain;
    busy      = drain;
    out_data  = drain ? shadow_q[idx_q] : '0;
    out_index = drain ? idx_q : '0;
    out_last  = drain && (idx_q == LAST);
    done      = done_q;
    overrun   = overrun_q;
  end

endmodule

// File: doc/pe_sum_drain.md
Name: pe_sum_drain

Overview:
- Read-side counterpart of the per-PE output registers.
- On a capture strobe it snapshots the registered 20-bit partial sums of all NUM_PE processing elements into a shadow buffer. It then streams them out one per handshake on a valid/ready interface, in PE index order.
- It sits between the PE array output registers and the output buffer/writeback logic. The PE array can keep accumulating the next tile while the previous tile's sums are being drained.

Parameters:
- NUM_PE, 4, number of PE sums captured per snapshot (legal values 2..64).
- SUM_W, 20, width of each PE sum.
- IDX_W, 2, width of out_index; must equal ceil(log2(NUM_PE)).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; while low, all state is cleared immediately.
- capture  input  1  single-cycle strobe meaning "PE registers hold a finished tile".
- pe_sums  input  NUM_PE*SUM_W  concatenated registered PE sums; PE i occupies bits [i*SUM_W +: SUM_W].
- clear_overrun  input  1  clears the sticky overrun flag.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the current word.
- out_data  output  SUM_W  shadow sum of the current PE.
- out_index  output  IDX_W  PE index of out_data.
- out_last  output  1  high with the word for PE NUM_PE-1.
- busy  output  1  drain in progress (state DRAIN).
- done  output  1  one-cycle pulse after the final word is accepted.
- overrun  output  1  sticky: a capture was lost.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, overrun=0, shadow buffer all 0, state IDLE.
- The same values apply when reset falls mid-drain. The partial drain is abandoned with no done pulse.
- FSM states: IDLE and DRAIN. out_valid = busy = (state==DRAIN).
- IDLE with capture=1:
  - all NUM_PE sums are latched into the shadow buffer and idx <= 0;
  - state becomes DRAIN;
  - out_valid rises the next cycle (capture-to-first-word latency is 1 cycle).
- IDLE with capture=0: no change.
- DRAIN:
  - out_data = shadow[idx], out_index = idx, out_last = (idx==NUM_PE-1). All are registered or shadow-derived with no combinational path from pe_sums.
  - A transfer occurs on a cycle with out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_index and out_last hold stable.
  - Transfer with idx<NUM_PE-1: idx <= idx+1.
  - Transfer with idx==NUM_PE-1: done=1 on the next cycle only; state becomes IDLE unless a back-to-back capture occurs (see below).
- Capture during DRAIN:
  - Outside the final-transfer cycle: the capture is ignored, the shadow buffer is untouched, and overrun <= 1.
  - In the same cycle as the final transfer (idx==NUM_PE-1 && out_ready): the capture is accepted. The shadow buffer is reloaded, idx <= 0, state stays DRAIN, done still pulses, overrun is unchanged. This allows back-to-back tiles with zero bubble.
- overrun:
  - Sets on a lost capture and holds until clear_overrun=1.
  - clear_overrun and a lost capture in the same cycle: the set wins, so overrun=1.
- out_ready is ignored in IDLE.
- Sums are passed through bit-exact, with no sign extension or saturation.
- Peak throughput is 1 word/cycle, so a full tile drains in NUM_PE cycles with out_ready held high.

Test Plan:
- Basic drain:
  - Stimulus: reset, then capture with pe_sums = {20'h00004, 20'h00003, 20'h00002, 20'h00001} and out_ready=1.
  - Required response: out_data is 1,2,3,4 on four consecutive cycles starting one cycle after capture; out_index is 0..3; out_last only with 4; done pulses once the following cycle; busy drops.
- Backpressure:
  - Stimulus: same tile, with out_ready low for 3 cycles at idx=1.
  - Required response: out_data holds 20'h00002 and out_index holds 1 throughout the stall; the sequence then completes in order; exactly 4 transfers.
- Snapshot isolation:
  - Stimulus: capture 20'hFFFFF in all lanes, then change pe_sums to 0 during the drain.
  - Required response: all four outputs are 20'hFFFFF.
- Overrun:
  - Stimulus: capture, then capture again at idx=1.
  - Required response: overrun=1; the drained data is the first tile; overrun persists after done; clear_overrun returns it to 0.
- Back-to-back:
  - Stimulus: a second capture coincident with the final transfer.
  - Required response: no overrun; done pulses; the second tile's word 0 appears the next cycle; busy stays high.
- Async reset:
  - Stimulus: assert reset low asynchronously at idx=2.
  - Required response: all outputs are 0 immediately without a clock edge; no done pulse; after release the block is IDLE and accepts a new capture.
